// File: rtl/add_sched.sv
// add_sched: round-robin front end sharing one nibble-serial adder between two requesters.
// Issues each accepted word LSB digit first and reassembles the returned sum digits.
module add_sched #(
    parameter int unsigned W   = 12,
    parameter int unsigned D   = 4,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         dp_in_valid,
    output logic         dp_first,
    output logic [D-1:0] dp_x,
    output logic [D-1:0] dp_y,
    input  logic [D-1:0] dp_s,
    input  logic         dp_c,
    output logic         res_valid,
    output logic         res_id,
    output logic [W-1:0] res_sum,
    output logic         res_cout
);
    localparam int unsigned N  = W / D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_dcnt;
    logic [CW-1:0] w_dcnt_nxt;
    logic          r_last;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_id;
    logic [W-1:0]  r_acc;

    // Tag pipeline; index 0 travels with the digit on the adder, index LAT with its sum.
    logic          r_pv  [0:LAT];
    logic          r_pl  [0:LAT];
    logic          r_pid [0:LAT];

    logic          w_last_dig;
    logic          w_next_last;
    logic          w_slot;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_accept;
    logic          w_cont;
    logic [W-1:0]  w_sel_a;
    logic [W-1:0]  w_sel_b;
    logic [W-1:0]  w_shift;

    // Arbitration, handshake and next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_last_dig  = (r_dcnt == CW'(N - 1));
        w_next_last = (CW'(r_dcnt + 1'b1) == CW'(N - 1));
        w_slot      = !rst && ((r_state == S_IDLE) || w_last_dig);
        w_gnt0      = req0_valid && (!req1_valid || r_last);
        w_gnt1      = req1_valid && !w_gnt0;
        w_rdy0      = w_slot && w_gnt0;
        w_rdy1      = w_slot && w_gnt1;
        w_accept    = w_rdy0 || w_rdy1;
        w_cont      = (r_state == S_ISSUE) && !w_last_dig;
        w_sel_a     = w_gnt1 ? req1_a : req0_a;
        w_sel_b     = w_gnt1 ? req1_b : req0_b;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                    w_dcnt_nxt  = '0;
                end
            end
            S_ISSUE: begin
                if (w_last_dig) begin
                    w_dcnt_nxt = '0;
                    if (!w_accept) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_dcnt_nxt = CW'(r_dcnt + 1'b1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

    assign req0_ready  = w_rdy0;
    assign req1_ready  = w_rdy1;
    assign dp_in_valid = r_pv[0];
    assign w_shift     = W'({dp_s, r_acc} >> D);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Digit issue: operands shift right so the low digit is always the next one out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            dp_first <= 1'b0;
            dp_x     <= '0;
            dp_y     <= '0;
            r_pv[0]  <= 1'b0;
            r_pl[0]  <= 1'b0;
            r_pid[0] <= 1'b0;
        end else begin
            dp_first <= w_accept;
            if (w_accept) begin
                dp_x     <= w_sel_a[D-1:0];
                dp_y     <= w_sel_b[D-1:0];
                r_a      <= W'(w_sel_a >> D);
                r_b      <= W'(w_sel_b >> D);
                r_id     <= w_gnt1;
                r_last   <= w_gnt1;
                r_pv[0]  <= 1'b1;
                r_pl[0]  <= (N == 1);
                r_pid[0] <= w_gnt1;
            end else if (w_cont) begin
                dp_x     <= r_a[D-1:0];
                dp_y     <= r_b[D-1:0];
                r_a      <= W'(r_a >> D);
                r_b      <= W'(r_b >> D);
                r_pv[0]  <= 1'b1;
                r_pl[0]  <= w_next_last;
                r_pid[0] <= r_id;
            end else begin
                dp_x     <= '0;
                dp_y     <= '0;
                r_pv[0]  <= 1'b0;
                r_pl[0]  <= 1'b0;
                r_pid[0] <= 1'b0;
            end
        end
    end

    // Sum reassembly: returning digits enter from the MSB side
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i <= LAT; i++) begin
                r_pv[i]  <= 1'b0;
                r_pl[i]  <= 1'b0;
                r_pid[i] <= 1'b0;
            end
            r_acc     <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
        end else begin
            for (int unsigned i = 1; i <= LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pl[i]  <= r_pl[i-1];
                r_pid[i] <= r_pid[i-1];
            end
            res_valid <= 1'b0;
            if (r_pv[LAT]) begin
                r_acc <= w_shift;
                if (r_pl[LAT]) begin
                    res_valid <= 1'b1;
                    res_sum   <= w_shift;
                    res_cout  <= dp_c;
                    res_id    <= r_pid[LAT];
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed vector table plus hand-written multi-cycle sequences,
// with a behavioural LAT=1 nibble adder whose carry clears on dp_first.
module tb_add_sched;
    localparam int unsigned W   = 12;
    localparam int unsigned D   = 4;
    localparam int unsigned LAT = 1;
    localparam int unsigned N   = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         dp_in_valid, dp_first;
    logic [D-1:0] dp_x, dp_y, dp_s;
    logic         dp_c;
    logic         res_valid, res_id, res_cout;
    logic [W-1:0] res_sum;

    always #5 clk = ~clk;

    add_sched #(.W(W), .D(D), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .dp_in_valid(dp_in_valid), .dp_first(dp_first), .dp_x(dp_x), .dp_y(dp_y),
        .dp_s(dp_s), .dp_c(dp_c),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout)
    );

    // Behavioural adder, one cycle latency
    logic         m_carry;
    logic [D:0]   m_tmp;
    assign m_tmp = {1'b0, dp_x} + {1'b0, dp_y} + {{D{1'b0}}, (dp_first ? 1'b0 : m_carry)};
    always @(posedge clk) begin
        if (rst) begin
            dp_s    <= '0;
            dp_c    <= 1'b0;
            m_carry <= 1'b0;
        end else if (dp_in_valid) begin
            dp_s    <= m_tmp[D-1:0];
            dp_c    <= m_tmp[D];
            m_carry <= m_tmp[D];
        end
    end

    typedef struct {logic [W-1:0] sum; logic cout; logic id; int cyc;} res_t;
    typedef struct {logic id; int cyc;} acc_t;
    res_t res_q[$];
    acc_t acc_q[$];
    int   cyc = 0;
    int   dpv_run = 0, dpv_max = 0, dpv_tot = 0;
    bit   both_rdy = 1'b0;
    int   n_vec = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples well after the drivers settle
    always @(negedge clk) begin
        #2;
        if (res_valid) res_q.push_back('{res_sum, res_cout, res_id, cyc});
        if (req0_valid && req0_ready) acc_q.push_back('{1'b0, cyc});
        if (req1_valid && req1_ready) acc_q.push_back('{1'b1, cyc});
        if (req0_ready && req1_ready) both_rdy = 1'b1;
        if (dp_in_valid) begin
            dpv_tot++;
            dpv_run++;
            if (dpv_run > dpv_max) dpv_max = dpv_run;
        end else begin
            dpv_run = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        res_q.delete();
        acc_q.delete();
        dpv_tot  = 0;
        dpv_max  = 0;
        both_rdy = 1'b0;
    endtask

    // Call just after a negedge; returns just after the accepting posedge
    task automatic send(input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        if (r) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            if (r ? req1_ready : req0_ready) begin
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dp_in_valid"}, 32'(dp_in_valid), 32'(0));
        chk({tag, "_dp_first"},    32'(dp_first),    32'(0));
        chk({tag, "_dp_x"},        32'(dp_x),        32'(0));
        chk({tag, "_dp_y"},        32'(dp_y),        32'(0));
        chk({tag, "_res_valid"},   32'(res_valid),   32'(0));
        chk({tag, "_res_sum"},     32'(res_sum),     32'(0));
        chk({tag, "_res_cout"},    32'(res_cout),    32'(0));
        chk({tag, "_res_id"},      32'(res_id),      32'(0));
    endtask

    typedef struct {bit r; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] sum; logic cout;} vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ta, tb2;
        logic [W-1:0] s_a[4], s_b[4], s_sum[4];

        tbl[0] = '{1'b0, 12'h9CB, 12'h364, 12'hD2F, 1'b0};
        tbl[1] = '{1'b0, 12'hFFF, 12'h001, 12'h000, 1'b1};
        tbl[2] = '{1'b0, 12'h001, 12'h001, 12'h002, 1'b0};
        tbl[3] = '{1'b1, 12'h800, 12'h800, 12'h000, 1'b1};
        tbl[4] = '{1'b1, 12'h123, 12'h456, 12'h579, 1'b0};
        tbl[5] = '{1'b0, 12'h0F0, 12'h010, 12'h100, 1'b0};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("reset_req0_ready", 32'(req0_ready), 32'(0));
        chk("reset_req1_ready", 32'(req1_ready), 32'(0));
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single words: digit order, first flag, latency and result fields
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            send(tbl[v].r, tbl[v].a, tbl[v].b);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
                if (k <= int'(N)) begin
                    ta  = tbl[v].a >> (D * (k - 1));
                    tb2 = tbl[v].b >> (D * (k - 1));
                    chk($sformatf("v%0d_d%0d_dp_in_valid", v, k - 1), 32'(dp_in_valid), 32'(1));
                    chk($sformatf("v%0d_d%0d_dp_first", v, k - 1), 32'(dp_first), 32'(k == 1));
                    chk($sformatf("v%0d_d%0d_dp_x", v, k - 1), 32'(dp_x), 32'(ta[D-1:0]));
                    chk($sformatf("v%0d_d%0d_dp_y", v, k - 1), 32'(dp_y), 32'(tb2[D-1:0]));
                end else begin
                    chk($sformatf("v%0d_k%0d_dp_in_valid", v, k), 32'(dp_in_valid), 32'(0));
                end
                chk($sformatf("v%0d_k%0d_res_valid", v, k), 32'(res_valid), 32'(k == 5));
                if (k == 5) begin
                    chk($sformatf("v%0d_res_sum", v), 32'(res_sum), 32'(tbl[v].sum));
                    chk($sformatf("v%0d_res_cout", v), 32'(res_cout), 32'(tbl[v].cout));
                    chk($sformatf("v%0d_res_id", v), 32'(res_id), 32'(tbl[v].r));
                end
            end
        end

        // Gapless stream on requester 0
        s_a[0] = 12'h09F; s_b[0] = 12'h671; s_sum[0] = 12'h710;
        s_a[1] = 12'h5A0; s_b[1] = 12'h3F4; s_sum[1] = 12'h994;
        s_a[2] = 12'h50F; s_b[2] = 12'h8E1; s_sum[2] = 12'hDF0;
        s_a[3] = 12'hC19; s_b[3] = 12'h360; s_sum[3] = 12'hF79;
        @(negedge clk);
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, s_a[i], s_b[i]);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("stream_dpv_run", 32'(dpv_max), 32'(12));
        chk("stream_dpv_tot", 32'(dpv_tot), 32'(12));
        chk("stream_res_count", 32'(res_q.size()), 32'(4));
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            chk($sformatf("stream_sum%0d", i), 32'(res_q[i].sum), 32'(s_sum[i]));
            chk($sformatf("stream_cout%0d", i), 32'(res_q[i].cout), 32'(0));
            chk($sformatf("stream_id%0d", i), 32'(res_q[i].id), 32'(0));
            if (i > 0) chk($sformatf("stream_gap%0d", i), 32'(res_q[i].cyc - res_q[i-1].cyc), 32'(3));
        end

        // Both requesters saturated straight out of reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        fork
            begin
                send(1'b0, 12'h111, 12'h222);
                @(negedge clk);
                send(1'b0, 12'h0AA, 12'h055);
                @(negedge clk);
                req0_valid = 1'b0;
            end
            begin
                send(1'b1, 12'h700, 12'h900);
                @(negedge clk);
                send(1'b1, 12'h321, 12'h123);
                @(negedge clk);
                req1_valid = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("alt_both_ready", 32'(both_rdy), 32'(0));
        chk("alt_acc_count", 32'(acc_q.size()), 32'(4));
        chk("alt_res_count", 32'(res_q.size()), 32'(4));
        chk("alt_dpv_run", 32'(dpv_max), 32'(12));
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            chk($sformatf("alt_grant%0d", i), 32'(acc_q[i].id), 32'(i % 2));
            if (i > 0) chk($sformatf("alt_gap%0d", i), 32'(acc_q[i].cyc - acc_q[i-1].cyc), 32'(3));
        end
        begin
            logic [W-1:0] e_sum[4];
            logic         e_cout[4];
            e_sum[0] = 12'h333; e_cout[0] = 1'b0;
            e_sum[1] = 12'h000; e_cout[1] = 1'b1;
            e_sum[2] = 12'h0FF; e_cout[2] = 1'b0;
            e_sum[3] = 12'h444; e_cout[3] = 1'b0;
            for (int i = 0; i < 4 && i < res_q.size(); i++) begin
                chk($sformatf("alt_res_id%0d", i), 32'(res_q[i].id), 32'(i % 2));
                chk($sformatf("alt_res_sum%0d", i), 32'(res_q[i].sum), 32'(e_sum[i]));
                chk($sformatf("alt_res_cout%0d", i), 32'(res_q[i].cout), 32'(e_cout[i]));
            end
        end

        // req1 alone, req0 raised mid-word takes the next slot with no bubble
        @(negedge clk);
        clear_mon();
        send(1'b1, 12'h456, 12'h111);
        @(negedge clk);
        req1_valid = 1'b0;
        send(1'b0, 12'h010, 12'h020);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_acc_count", 32'(acc_q.size()), 32'(2));
        if (acc_q.size() == 2) begin
            chk("mid_acc_id0", 32'(acc_q[0].id), 32'(1));
            chk("mid_acc_id1", 32'(acc_q[1].id), 32'(0));
            chk("mid_acc_gap", 32'(acc_q[1].cyc - acc_q[0].cyc), 32'(3));
        end
        chk("mid_dpv_run", 32'(dpv_max), 32'(6));
        chk("mid_res_count", 32'(res_q.size()), 32'(2));
        if (res_q.size() == 2) begin
            chk("mid_sum0", 32'(res_q[0].sum), 32'(12'h567));
            chk("mid_id0", 32'(res_q[0].id), 32'(1));
            chk("mid_sum1", 32'(res_q[1].sum), 32'(12'h030));
            chk("mid_id1", 32'(res_q[1].id), 32'(0));
        end

        // Reset pulse during digit 1 discards the in-flight word
        @(negedge clk);
        clear_mon();
        send(1'b0, 12'h9CB, 12'h364);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_dp_x_d1", 32'(dp_x), 32'(4'hC));
        chk("rstmid_dp_first_d1", 32'(dp_first), 32'(0));
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 12'h001; req0_b = 12'h002;
        req1_valid = 1'b1;
        #1;
        chk("rstmid_req0_ready", 32'(req0_ready), 32'(0));
        chk("rstmid_req1_ready", 32'(req1_ready), 32'(0));
        req1_valid = 1'b0;
        @(negedge clk);
        chk_zero("rstmid");
        rst = 1'b0;
        send(1'b0, 12'h001, 12'h002);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_res_count", 32'(res_q.size()), 32'(1));
        if (res_q.size() >= 1) begin
            chk("rstmid_sum", 32'(res_q[0].sum), 32'(12'h003));
            chk("rstmid_cout", 32'(res_q[0].cout), 32'(0));
            chk("rstmid_id", 32'(res_q[0].id), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_sched.md
# add_sched

Controller that shares one nibble-serial adder (4-bit digit, carry held inside the adder between digits) between two requesters. It accepts 12-bit operand pairs through valid/ready handshakes and arbitrates round-robin between the requesters. It issues each word to the adder LSB digit first and reassembles the returned sum digits into a 12-bit result with carry-out and requester ID. It sits between the operand sources and the digit-serial adder `top` datapath.

## Interface
- `W`, 12, operand/result word width; must be a multiple of `D`
- `D`, 4, digit width; `N = W/D` digits per word (3 by default)
- `LAT`, 1, adder latency in cycles from `dp_in_valid` digit to matching `dp_s`/`dp_c`; ≥1
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `req0_valid` in 1 — requester 0 has an operand pair
- `req0_a`, `req0_b` in W — requester 0 operands
- `req0_ready` out 1 — requester 0 pair accepted this cycle when valid&ready
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready` — same for requester 1
- `dp_in_valid` out 1 — digit presented to adder
- `dp_first` out 1 — first (LSB) digit of a word; adder uses carry-in 0
- `dp_x`, `dp_y` out D — operand digits
- `dp_s` in D — sum digit, valid LAT cycles after its issue
- `dp_c` in 1 — adder carry after the digit; sampled on last digit only
- `res_valid` out 1 — one-cycle result pulse, no backpressure
- `res_id` out 1 — requester that owns the result
- `res_sum` out W, `res_cout` out 1 — sum word, carry-out

## Operation
- States: IDLE, ISSUE. Digit counter `dcnt` 0..N-1; round-robin pointer `last` (last granted ID).
- Arbitration: when exactly one valid, grant it. When both valid, grant `!last`. The granted requester's ready is high only in IDLE, or in ISSUE at `dcnt==N-1`. `last` updates on acceptance.
- ready is combinational from valid/state. Requesters must not make valid depend on ready. Both readys are never high together.
- Acceptance latches a, b, and ID into shift registers. Next state is ISSUE with `dcnt=0`.
- ISSUE: drive digit `dcnt` (bits `[D*dcnt+D-1 : D*dcnt]`) registered on `dp_x`/`dp_y`, `dp_in_valid=1`, `dp_first=(dcnt==0)`. At `dcnt==N-1`: a new acceptance in the same cycle continues ISSUE with `dcnt=0` (gapless). Otherwise go to IDLE.
- Tag pipeline (valid, last-digit, ID) is delayed LAT cycles alongside the adder. Each returning digit shifts into the result register from the MSB side. On the last digit, `dp_c` is captured and `res_valid` pulses next cycle with `res_sum`, `res_cout`, `res_id`. `res_sum`/`res_cout`/`res_id` hold until the next result.
- Sum is modulo 2^W; the only overflow indication is `res_cout`.
- Reset: IDLE, `dcnt=0`, `last=1` (req0 wins first tie), tag pipeline cleared. In-flight words are discarded and produce no `res_valid`. All registered outputs are 0. readys are forced 0 while `rst` is high.

## Timing
- Accept at cycle T. Digits are on the adder at T+1..T+N. Last sum digit returns at T+N+LAT. `res_valid` is at T+N+LAT+1 (T+5 by default).
- Sustained throughput: one word per N cycles with both requesters saturated. `dp_in_valid` stays continuously high.
- Maximum words in flight: ceil((N+LAT+1)/N). Results return in acceptance order.
- `rst` asserted at cycle R: at R+1 all outputs are 0, no ready is high, and no stale `res_valid` appears afterwards.

## Test plan
Use a behavioural adder model with LAT=1 and internal carry cleared on `dp_first`.
- req0 only, 0x9CB+0x364 → `dp_x` sequence B,C,9 with `dp_first` on B; `res_valid` 5 cycles after accept; `res_sum`=0xD2F, `res_cout`=0, `res_id`=0.
- req0 stream 0x09F+0x671, 0x5A0+0x3F4, 0x50F+0x8E1, 0xC19+0x360 held valid → gapless `dp_in_valid` for 12 cycles; results 0x710, 0x994, 0xDF0, 0xF79, each `res_cout`=0, 3 cycles apart.
- Carry out: 0xFFF+0x001 → `res_sum`=0x000, `res_cout`=1. Then 0x001+0x001 → 0x002, `res_cout`=0, proving carry is cleared at `dp_first`.
- Both valid continuously after reset → grants alternate 0,1,0,1. `res_id` alternates the same way. Readys are never simultaneously high.
- req1 valid first, req0 raised mid-word → req0 granted at req1's last digit with no bubble.
- `rst` pulsed one cycle during digit 1 of 0x9CB+0x364 → no `res_valid` for that word; all outputs 0 the next cycle. A following 0x001+0x002 returns 0x003 with `res_id`=0.
